// File: rtl/long_string_renderer.sv
// long_string_renderer: fetches per-line string ROM rows into slot buffers during blanking and serialises them into a pixel stream
module long_string_renderer #(
  parameter int STR0_BASE = 0,
  parameter int STR1_BASE = 17,
  parameter int ROWS      = 16,
  parameter int STR_W     = 72,
  parameter int CW        = 11
) (
  input  logic             VGA_CLK,
  input  logic             Reset_n,
  input  logic [1:0]       Enable,
  input  logic [CW-1:0]    X0,
  input  logic [CW-1:0]    Y0,
  input  logic [CW-1:0]    X1,
  input  logic [CW-1:0]    Y1,
  input  logic             Line_Start,
  input  logic [CW-1:0]    Next_Line,
  input  logic [CW-1:0]    H_Count,
  output logic [4:0]       String_Address,
  input  logic [STR_W-1:0] String_Data,
  output logic             Pixel_On,
  output logic             Pixel_Slot,
  output logic             Busy,
  output logic             Fetch_Overrun,
  input  logic             Clear_Overrun
);
  typedef enum logic [2:0] {IDLE, W0, C0, W1, C1} state_t;
  state_t state, state_nx;
  logic [CW-1:0] r0, r1, c0, c1;
  logic [STR_W-1:0] buf0, buf1, sh0, sh1;
  logic [3:0] row1;
  logic hit0, hit1, start, p0, p1;
  assign start = Line_Start & (state == IDLE);
  assign r0 = Next_Line - Y0;
  assign r1 = Next_Line - Y1;
  assign c0 = H_Count - X0;
  assign c1 = H_Count - X1;
  assign sh0 = buf0 << c0;
  assign sh1 = buf1 << c1;
  assign p0 = (H_Count >= X0) & (c0 < CW'(STR_W)) & sh0[STR_W-1];
  assign p1 = (H_Count >= X1) & (c1 < CW'(STR_W)) & sh1[STR_W-1];
  // fetch sequencer state register
  always_ff @(posedge VGA_CLK)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  // fixed five-cycle walk: issue slot 0 read, capture it, issue slot 1 read, capture it
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Line_Start ? W0 : IDLE;
      W0:      state_nx = C0;
      C0:      state_nx = W1;
      W1:      state_nx = C1;
      default: state_nx = IDLE;
    endcase
  end
  // ROM addressing, row capture, overrun flag and the one-cycle pixel pipeline
  always_ff @(posedge VGA_CLK)
    if (!Reset_n) begin
      String_Address <= '0;
      buf0 <= '0;
      buf1 <= '0;
      hit0 <= 1'b0;
      hit1 <= 1'b0;
      row1 <= '0;
      Busy <= 1'b0;
      Fetch_Overrun <= 1'b0;
      Pixel_On <= 1'b0;
      Pixel_Slot <= 1'b0;
    end else begin
      if (start) begin
        String_Address <= 5'(STR0_BASE) + 5'(r0[3:0]);
        hit0 <= Enable[0] & (Next_Line >= Y0) & (r0 < CW'(ROWS));
        hit1 <= Enable[1] & (Next_Line >= Y1) & (r1 < CW'(ROWS));
        row1 <= r1[3:0];
        Busy <= 1'b1;
      end
      if (state == C0) begin
        buf0 <= hit0 ? String_Data : '0;
        String_Address <= 5'(STR1_BASE) + 5'(row1);
      end
      if (state == C1) begin
        buf1 <= hit1 ? String_Data : '0;
        Busy <= 1'b0;
      end
      Fetch_Overrun <= (Line_Start & Busy) | (Fetch_Overrun & ~Clear_Overrun);
      Pixel_On <= p0 | p1;
      Pixel_Slot <= ~p0 & p1;
    end
endmodule

// File: doc/long_string_renderer.md
Name: long_string_renderer

Overview:
- Sequences the 72-pixel-wide string bitmap ROM for two on-screen label slots: slot 0 ("Streaming", 16 rows) and slot 1 ("Vp-p", 16 rows).
- During each horizontal blanking interval it fetches the ROM row each slot needs for the coming line and latches it into a per-slot row buffer. During active video it serialises those buffers into a pixel-on stream.
- Sits between the VGA timing generator and the overlay colour mux in the Memory Management path. It is the sole master of the string ROM port.

Parameters:
- STR0_BASE, 0, ROM address of row 0 of slot 0.
- STR1_BASE, 17, ROM address of row 0 of slot 1.
- ROWS, 16, bitmap height in rows, same for both slots.
- STR_W, 72, bitmap width in pixels; equals ROM data width.
- CW, 11, width of coordinate and counter inputs.

Ports:
- VGA_CLK  in  1  pixel clock; sole clock.
- Reset_n  in  1  synchronous, active-low reset.
- Enable  in  2  per-slot display enable; bit0 = slot 0, bit1 = slot 1.
- X0, Y0  in  CW each  top-left pixel of slot 0.
- X1, Y1  in  CW each  top-left pixel of slot 1.
- Line_Start  in  1  one-cycle pulse, issued in horizontal blanking, requesting a fetch for line Next_Line.
- Next_Line  in  CW  vertical coordinate of the line about to be displayed; sampled with Line_Start.
- H_Count  in  CW  current horizontal pixel coordinate.
- String_Address  out  5  ROM address, registered.
- String_Data  in  72  ROM read data; the ROM has one registered read cycle.
- Pixel_On  out  1  current pixel belongs to a lit string bit.
- Pixel_Slot  out  1  slot owning the lit pixel (0 or 1).
- Busy  out  1  fetch sequence in progress.
- Fetch_Overrun  out  1  sticky: Line_Start arrived while Busy.
- Clear_Overrun  in  1  clears Fetch_Overrun.

Behaviour:
- Reset (Reset_n = 0 at a VGA_CLK edge):
  - Outputs: String_Address = 0, Pixel_On = 0, Pixel_Slot = 0, Busy = 0, Fetch_Overrun = 0.
  - Internal: both row buffers = 0, hit flags = 0, FSM = IDLE.
  - Reset mid-fetch aborts the sequence; the partially fetched row is discarded.
- FSM states: IDLE, W0, C0, W1, C1.
- IDLE:
  - On Line_Start, latch Next_Line into L.
  - Compute r0 = L − Y0 and hit0 = Enable[0] & (L ≥ Y0) & (r0 < ROWS). Compute r1 and hit1 likewise for slot 1.
  - String_Address <= (STR0_BASE + r0[3:0]) mod 32. Busy <= 1. Go to W0.
- W0: ROM samples the address. Go to C0.
- C0:
  - Row_Buf0 <= hit0 ? String_Data : 0.
  - String_Address <= (STR1_BASE + r1[3:0]) mod 32.
  - Go to W1.
- W1: go to C1.
- C1: Row_Buf1 <= hit1 ? String_Data : 0. Busy <= 0. Go to IDLE.
- Timing:
  - Fixed 5-cycle fetch. Both reads are always issued, even on a miss, so timing is deterministic.
  - Busy is high in the 4 cycles after the Line_Start edge.
  - Address arithmetic wraps modulo 32; no range check beyond the ROWS test.
- Line_Start while Busy: ignored, and Fetch_Overrun <= 1.
  - Clear_Overrun clears the flag. If Clear_Overrun and a new overrun occur in the same cycle, set wins.
- Row buffers update only in C0/C1. The timing generator guarantees Line_Start is at least 5 cycles before active video, so buffers are stable during display.
- Pixel path (pipelined, 1-cycle latency from H_Count):
  - c0 = H_Count − X0; p0 = (H_Count ≥ X0) & (c0 < STR_W) & Row_Buf0[STR_W−1−c0]. Bit 71 is the leftmost pixel.
  - p1 is computed the same way for slot 1.
  - Pixel_On <= p0 | p1. Pixel_Slot <= ~p0 & p1, so slot 0 has priority on overlap.
- Enable deasserted mid-frame takes effect at the next Line_Start. The current line finishes from its latched buffer.
- X + STR_W beyond the screen edge: pixels past the last H_Count are simply never shown; no wrap.

Test Plan:
- Reset_n = 0 for 3 cycles during W1 → all outputs 0, FSM IDLE, Row_Buf1 = 0; next Line_Start starts a clean fetch.
- Y0 = 100, Enable = 01, Line_Start with Next_Line = 105 → String_Address = 5 during W0/C0 and 17+? during W1/C1. Row_Buf0 = ROM[5] = 72'h7C_C3...; Busy high 4 cycles. Row_Buf1 = 0 (slot disabled).
- Y1 = 200, Next_Line = 215 → address 17+15 = 32 wraps to 0; Row_Buf1 = ROM[0] = 0. Next_Line = 216 → hit1 = 0, Row_Buf1 = 0.
- X0 = 10, Row_Buf0 = ROM[5], sweep H_Count 0..90 → Pixel_On one cycle later equals bit (81 − H_Count) for H_Count 10..81, and 0 elsewhere.
- Overlapping slots (X0 = X1, Y0 = Y1, both enabled) → Pixel_Slot = 0 wherever slot 0's bit is 1; Pixel_Slot = 1 only where slot 0 = 0 and slot 1 = 1.
- Line_Start 2 cycles after a previous Line_Start → second pulse ignored, Fetch_Overrun = 1. It stays set until Clear_Overrun, and stays 1 if another overrun occurs in the same cycle as Clear_Overrun.
